// File: rtl/bias_loader.sv
// Streams one bias word per neuron into the layer's bias memories, then optionally
// reads each memory back and flags the first neuron whose stored value differs.
module bias_loader #(
   parameter int data_bits   = 16,
   parameter int num_neurons = 8,
   parameter int idx_bits    = (num_neurons > 1) ? $clog2(num_neurons) : 1,
   parameter bit verify      = 1'b1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             s_valid,
   input  logic [data_bits-1:0]             s_data,
   output logic                             s_ready,
   output logic [num_neurons-1:0]           bias_write_en,
   output logic [data_bits-1:0]             bias_data,
   output logic [num_neurons-1:0]           bias_read_en,
   input  logic [num_neurons*data_bits-1:0] bias_out_bus,
   output logic                             busy,
   output logic                             done,
   output logic                             mismatch,
   output logic [idx_bits-1:0]              mismatch_idx
);
   typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY_RD, VERIFY_CMP} state_t;

   localparam logic [idx_bits-1:0] last_idx = idx_bits'(num_neurons - 1);

   state_t                 state, state_n;
   logic [idx_bits-1:0]    idx, vidx;
   logic [data_bits-1:0]   shadow [num_neurons];
   logic [num_neurons-1:0] sel_w, sel_v;
   logic [data_bits-1:0]   rd_sel, sh_sel;
   logic                   hs, finish, cmp_bad;

   for (genvar g = 0; g < num_neurons; g++) begin : g_sel
      assign sel_w[g] = (idx == idx_bits'(g));
      assign sel_v[g] = (vidx == idx_bits'(g));
   end

   // Per-neuron slice of the read-back bus and the word we sent to it.
   always_comb begin
      rd_sel = '0;
      sh_sel = '0;
      for (int i = 0; i < num_neurons; i++)
         if (sel_v[i]) begin
            rd_sel = bias_out_bus[i*data_bits +: data_bits];
            sh_sel = shadow[i];
         end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n      = state;
      hs           = 1'b0;
      finish       = 1'b0;
      cmp_bad      = 1'b0;
      s_ready      = 1'b0;
      bias_read_en = '0;
      unique case (state)
         IDLE: if (start) state_n = LOAD;
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               hs = 1'b1;
               if (idx == last_idx) state_n = FLUSH;
            end
         end
         // Final write strobe is on the bus this cycle; reading earlier would race it.
         FLUSH: begin
            if (verify) state_n = VERIFY_RD;
            else begin
               state_n = IDLE;
               finish  = 1'b1;
            end
         end
         VERIFY_RD: begin
            bias_read_en = sel_v;
            state_n      = VERIFY_CMP;
         end
         VERIFY_CMP: begin
            cmp_bad = (rd_sel != sh_sel);
            if (vidx == last_idx) begin
               state_n = IDLE;
               finish  = 1'b1;
            end else state_n = VERIFY_RD;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx           <= '0;
         vidx          <= '0;
         bias_write_en <= '0;
         bias_data     <= '0;
         done          <= 1'b0;
         mismatch      <= 1'b0;
         mismatch_idx  <= '0;
      end else begin
         bias_write_en <= hs ? sel_w : '0;
         done          <= finish;
         if (state == IDLE && start) begin
            idx          <= '0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
         end
         if (hs) begin
            bias_data <= s_data;
            if (idx != last_idx) idx <= idx + 1'b1;
         end
         if (state == FLUSH) vidx <= '0;
         if (state == VERIFY_CMP && vidx != last_idx) vidx <= vidx + 1'b1;
         // Only the first failing neuron is reported; later ones just keep the flag set.
         if (cmp_bad) begin
            mismatch <= 1'b1;
            if (!mismatch) mismatch_idx <= vidx;
         end
      end
   end

   always_ff @(posedge clk)
      for (int i = 0; i < num_neurons; i++)
         if (hs && sel_w[i]) shadow[i] <= s_data;

endmodule

// File: tb/tb_bias_loader.sv
// Three loaders (N=4 verify, N=4 no-verify, N=1 verify) share one stream; each is
// checked every cycle against a timing-rule model, plus a few directed scenarios.
module tb_bias_loader;
   localparam int U = 3;

   logic        clk = 1'b0;
   logic        reset, start, s_valid, mem_clr;
   logic [15:0] s_data;
   bit          stuck [4];
   int          tests = 0, fails = 0, cyc = 0;

   always #5 clk = ~clk;

   logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2, mm0, mm1, mm2;
   logic [3:0]  we0, re0, we1, re1;
   logic [0:0]  we2, re2, mi2;
   logic [15:0] bd0, bd1, bd2, bus2;
   logic [1:0]  mi0, mi1;
   logic [63:0] bus0, bus1;

   bias_loader #(.data_bits(16), .num_neurons(4), .verify(1'b1)) u0 (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(rdy0), .bias_write_en(we0), .bias_data(bd0), .bias_read_en(re0),
      .bias_out_bus(bus0), .busy(busy0), .done(done0), .mismatch(mm0), .mismatch_idx(mi0));
   bias_loader #(.data_bits(16), .num_neurons(4), .verify(1'b0)) u1 (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(rdy1), .bias_write_en(we1), .bias_data(bd1), .bias_read_en(re1),
      .bias_out_bus(bus1), .busy(busy1), .done(done1), .mismatch(mm1), .mismatch_idx(mi1));
   bias_loader #(.data_bits(16), .num_neurons(1), .verify(1'b1)) u2 (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(rdy2), .bias_write_en(we2), .bias_data(bd2), .bias_read_en(re2),
      .bias_out_bus(bus2), .busy(busy2), .done(done2), .mismatch(mm2), .mismatch_idx(mi2));

   logic [3:0]  we_o [U], re_o [U];
   logic [15:0] bd_o [U];
   logic [1:0]  mi_o [U];
   logic        rdy_o [U], busy_o [U], done_o [U], mm_o [U];

   assign we_o[0] = we0;  assign we_o[1] = we1;  assign we_o[2] = {3'b000, we2};
   assign re_o[0] = re0;  assign re_o[1] = re1;  assign re_o[2] = {3'b000, re2};
   assign bd_o[0] = bd0;  assign bd_o[1] = bd1;  assign bd_o[2] = bd2;
   assign mi_o[0] = mi0;  assign mi_o[1] = mi1;  assign mi_o[2] = {1'b0, mi2};
   assign rdy_o[0] = rdy0;   assign rdy_o[1] = rdy1;   assign rdy_o[2] = rdy2;
   assign busy_o[0] = busy0; assign busy_o[1] = busy1; assign busy_o[2] = busy2;
   assign done_o[0] = done0; assign done_o[1] = done1; assign done_o[2] = done2;
   assign mm_o[0] = mm0;     assign mm_o[1] = mm1;     assign mm_o[2] = mm2;

   // Bias memory models: registered read, a stuck memory always reads 0xFFFF.
   logic [15:0] mem [U][4];
   logic [15:0] bout [U][4];
   always @(posedge clk)
      for (int u = 0; u < U; u++)
         for (int i = 0; i < 4; i++) begin
            if (mem_clr) begin
               mem[u][i]  <= '0;
               bout[u][i] <= '0;
            end else begin
               if (we_o[u][i]) mem[u][i] <= bd_o[u];
               if (re_o[u][i]) bout[u][i] <= stuck[i] ? 16'hFFFF : mem[u][i];
            end
         end
   assign bus0 = {bout[0][3], bout[0][2], bout[0][1], bout[0][0]};
   assign bus1 = {bout[1][3], bout[1][2], bout[1][1], bout[1][0]};
   assign bus2 = bout[2][0];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int nn(input int u); return (u == 2) ? 1 : 4; endfunction
   function automatic bit vf(input int u); return u != 1; endfunction

   // Model state: where each unit is in its load, and when its last word went in.
   bit          armed;
   bit          loading [U], hs_prev [U], mm_m [U], post_rst [U];
   int          cnt [U], t_last [U], hs_k [U], mmi_m [U];
   logic [15:0] words [U][4];
   logic [15:0] hs_d [U];
   int          obs_hs [U], obs_done [U], done_cnt [U];

   initial begin : compare
      int n, d, j, e_we, e_re, dlat;
      bit e_busy, e_done;
      logic [15:0] memv;
      armed = 1'b0;
      for (int u = 0; u < U; u++) begin
         t_last[u] = -1; loading[u] = 1'b0; hs_prev[u] = 1'b0; mm_m[u] = 1'b0;
         mmi_m[u] = 0; cnt[u] = 0; post_rst[u] = 1'b0; done_cnt[u] = 0;
         obs_hs[u] = 0; obs_done[u] = 0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < U; u++) begin
            n      = nn(u);
            dlat   = vf(u) ? 2 + 2*n : 2;
            d      = (t_last[u] >= 0) ? cyc - t_last[u] : -1;
            e_we   = hs_prev[u] ? (1 << hs_k[u]) : 0;
            e_re   = (vf(u) && d >= 2 && d <= 2*n && d % 2 == 0) ? (1 << ((d - 2) / 2)) : 0;
            e_done = (d == dlat);
            e_busy = loading[u] || (d >= 1 && d < dlat);
            if (armed) begin
               chk($sformatf("u%0d s_ready", u), int'(rdy_o[u]), int'(loading[u]));
               chk($sformatf("u%0d bias_write_en", u), int'(we_o[u]), e_we);
               chk($sformatf("u%0d bias_read_en", u), int'(re_o[u]), e_re);
               chk($sformatf("u%0d busy", u), int'(busy_o[u]), int'(e_busy));
               chk($sformatf("u%0d done", u), int'(done_o[u]), int'(e_done));
               chk($sformatf("u%0d mismatch", u), int'(mm_o[u]), int'(mm_m[u]));
               chk($sformatf("u%0d mismatch_idx", u), int'(mi_o[u]), mmi_m[u]);
               if (hs_prev[u] || post_rst[u])
                  chk($sformatf("u%0d bias_data", u), int'(bd_o[u]),
                      post_rst[u] ? 0 : int'(hs_d[u]));
            end
            if (rdy_o[u] && s_valid && !reset) obs_hs[u] = cyc;
            if (done_o[u]) begin
               obs_done[u] = cyc;
               done_cnt[u]++;
            end
            if (reset) begin
               loading[u] = 1'b0; cnt[u] = 0; t_last[u] = -1; hs_prev[u] = 1'b0;
               mm_m[u] = 1'b0; mmi_m[u] = 0; post_rst[u] = 1'b1;
            end else begin
               post_rst[u] = 1'b0;
               if (vf(u) && d >= 3 && d <= 2*n + 1 && d % 2 == 1) begin
                  j    = (d - 3) / 2;
                  memv = stuck[j] ? 16'hFFFF : words[u][j];
                  if (memv != words[u][j]) begin
                     if (!mm_m[u]) mmi_m[u] = j;
                     mm_m[u] = 1'b1;
                  end
               end
               hs_prev[u] = loading[u] && s_valid;
               if (hs_prev[u]) begin
                  hs_k[u] = cnt[u];
                  hs_d[u] = s_data;
                  words[u][cnt[u]] = s_data;
                  cnt[u]++;
                  if (cnt[u] == n) begin
                     loading[u] = 1'b0;
                     t_last[u]  = cyc;
                  end
               end
               if (start && !e_busy) begin
                  loading[u] = 1'b1; cnt[u] = 0; mm_m[u] = 1'b0; mmi_m[u] = 0; t_last[u] = -1;
               end
            end
         end
         if (reset) armed = 1'b1;
         cyc++;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy_o[0] || busy_o[1] || busy_o[2]) && k < 200) begin
         step;
         k++;
      end
      chk({name, " reaches idle"}, int'(busy_o[0] || busy_o[1] || busy_o[2]), 0);
      step;
      step;
   endtask

   task automatic load(input logic [15:0] base, input int gap, input int words_n);
      start = 1'b1;
      step;
      start = 1'b0;
      for (int k = 0; k < words_n; k++) begin
         s_valid = 1'b1;
         s_data  = base + 16'(k);
         step;
         if (k == 0 && gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) step;
         end
      end
      s_valid = 1'b0;
   endtask

   initial begin : stim
      int dc0;
      reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; mem_clr = 1'b1;
      for (int i = 0; i < 4; i++) stuck[i] = 1'b0;
      step; step;
      mem_clr = 1'b0;
      reset   = 1'b0;
      chk("reset busy", int'(busy0), 0);
      chk("reset s_ready", int'(rdy0), 0);
      chk("reset mismatch", int'(mm0), 0);

      // Back-to-back load of 1..4, a fifth word offered, start pulsed while busy.
      dc0 = done_cnt[0];
      start = 1'b1;
      step;
      start = 1'b0;
      chk("t1 busy after start", int'(busy0), 1);
      chk("t1 s_ready after start", int'(rdy0), 1);
      for (int k = 0; k < 5; k++) begin
         s_valid = 1'b1;
         s_data  = 16'h0001 + 16'(k);
         start   = (k == 1);
         step;
      end
      start = 1'b0; s_valid = 1'b0;
      wait_idle("t1");
      chk("t1 u0 done latency", obs_done[0] - obs_hs[0], 10);
      chk("t1 u1 done latency", obs_done[1] - obs_hs[1], 2);
      chk("t1 u2 done latency", obs_done[2] - obs_hs[2], 4);
      chk("t1 u0 done count", done_cnt[0] - dc0, 1);
      chk("t1 u0 mismatch", int'(mm0), 0);
      chk("t1 u1 mem3", int'(mem[1][3]), 16'h0004);

      // Three-cycle stall between words 1 and 2.
      load(16'h0011, 3, 4);
      wait_idle("t2");
      chk("t2 u0 done latency", obs_done[0] - obs_hs[0], 10);
      chk("t2 u0 mem1", int'(mem[0][1]), 16'h0012);
      chk("t2 u0 mem3", int'(mem[0][3]), 16'h0014);

      // Memory 2 stuck: first failure reported, verification runs to the end.
      dc0 = done_cnt[0];
      stuck[2] = 1'b1;
      load(16'h0A00, 0, 4);
      wait_idle("t3");
      chk("t3 u0 mismatch", int'(mm0), 1);
      chk("t3 u0 mismatch_idx", int'(mi0), 2);
      chk("t3 u0 done count", done_cnt[0] - dc0, 1);
      chk("t3 u1 mismatch", int'(mm1), 0);
      stuck[2] = 1'b0;

      // New start clears the sticky flag; reset mid-load after two words.
      start = 1'b1;
      step;
      start = 1'b0;
      chk("t4 mismatch cleared", int'(mm0), 0);
      for (int k = 0; k < 2; k++) begin
         s_valid = 1'b1;
         s_data  = 16'h5500 + 16'(k);
         step;
      end
      s_valid = 1'b0;
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("t4 reset busy", int'(busy0), 0);
      chk("t4 reset s_ready", int'(rdy0), 0);
      chk("t4 reset bias_data", int'(bd0), 0);
      step;
      chk("t4 mem0 kept", int'(mem[0][0]), 16'h5500);
      chk("t4 mem1 kept", int'(mem[0][1]), 16'h5501);
      chk("t4 mem2 old", int'(mem[0][2]), 16'h0A02);
      load(16'h6600, 0, 4);
      wait_idle("t4b");
      chk("t4b mem0 reloaded", int'(mem[0][0]), 16'h6600);
      chk("t4b mismatch", int'(mm0), 0);

      // Random traffic, starts, stalls, resets and stuck memories.
      for (int i = 0; i < 3000; i++) begin
         reset   = ($urandom_range(0, 299) == 0);
         start   = ($urandom_range(0, 9) == 0);
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = 16'($urandom);
         if (!busy_o[0] && !busy_o[1] && !busy_o[2] && !start)
            for (int j = 0; j < 4; j++) stuck[j] = ($urandom_range(0, 4) == 0);
         step;
      end
      reset = 1'b0; start = 1'b0; s_valid = 1'b0;
      repeat (40) step;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bias_loader.md
# bias_loader

Streaming writer that fills a layer's per-neuron bias memories from a valid/ready word stream, then optionally reads every bias back through the memories' `read_en`/`bias_out` port and compares it with what was written. Sits between the host/DMA parameter stream and the `num_neurons` bias memories of one layer. It drives their `write_en`/`bias_in` and `read_en` inputs and observes their `bias_out` outputs.

## Interface
- `data_bits`, 16, width of one bias word
- `num_neurons`, 8, number of bias memories driven (≥1)
- `idx_bits`, `$clog2(num_neurons)` (min 1), neuron index width
- `verify`, 1, 1 = read-back check after load; 0 = skip

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `s_valid`  in  1  stream word valid
- `s_data`  in  data_bits  stream word; word k goes to neuron k
- `s_ready`  out  1  loader accepts a word
- `bias_write_en`  out  num_neurons  one-hot write strobe to memory i
- `bias_data`  out  data_bits  shared write data to all memories
- `bias_read_en`  out  num_neurons  one-hot read strobe to memory i
- `bias_out_bus`  in  num_neurons*data_bits  memory i `bias_out` at `[i*data_bits +: data_bits]`
- `busy`  out  1  load/verify in progress
- `done`  out  1  one-cycle completion pulse
- `mismatch`  out  1  sticky read-back failure; cleared by `start`
- `mismatch_idx`  out  idx_bits  index of the first failing neuron

## Operation
- States: IDLE, LOAD, FLUSH, VERIFY_RD, VERIFY_CMP.
- IDLE: `s_ready`=0. `start`=1 clears `mismatch`/`mismatch_idx`, sets idx=0, and moves to LOAD.
- LOAD: `s_ready`=1. Handshake is `s_valid && s_ready`. On each handshake, store `s_data` in shadow[idx] and issue a write to neuron idx. If idx==num_neurons-1, go to FLUSH; otherwise idx++.
- FLUSH: one cycle that lets the final write land. Then go to VERIFY_RD with vidx=0 if `verify`=1; otherwise go to IDLE with `done`.
- VERIFY_RD: `bias_read_en[vidx]`=1 for one cycle, then go to VERIFY_CMP.
- VERIFY_CMP: compare slice vidx of `bias_out_bus` with shadow[vidx].
  - On inequality: set `mismatch`=1. Load `mismatch_idx`=vidx only if `mismatch` was 0.
  - If vidx==num_neurons-1, go to IDLE with `done`; otherwise vidx++ and go to VERIFY_RD.
- Verification always covers every neuron; a mismatch does not abort it.
- `busy`=1 in LOAD, FLUSH, VERIFY_*.
- `start` while busy is ignored. `s_valid` outside LOAD is not consumed.
- `bias_write_en` and `bias_read_en` are never both nonzero in the same cycle, and each has at most one bit set.
- Reset (any state, including mid-load):
  - State goes to IDLE and idx/vidx to 0.
  - All outputs go to 0: `s_ready`, `bias_write_en`, `bias_data`, `bias_read_en`, `busy`, `done`, `mismatch`, `mismatch_idx`.
  - Memories already written keep their contents.
- In pretrained builds the memories ignore `write_en`, so read-back reports `mismatch`. This is the intended diagnostic.

## Timing
- `start` in cycle s → `busy`=1 and `s_ready`=1 from s+1.
- Handshake for neuron k in cycle t → `bias_write_en[k]`=1 and `bias_data`=word in cycle t+1 only. The memory captures the word at the end of t+1.
- Last handshake at cycle t:
  - FLUSH is active in t+1, concurrent with the final write strobe.
  - `verify`=0: `done`=1 and `busy`=0 in cycle t+2.
  - `verify`=1: `bias_read_en[j]` is high in cycle t+2+2j. The memory output is valid, and compared, in t+3+2j. `done` pulses in t+2+2N with `busy`=0.
- `mismatch` updates at the end of the compare cycle, so it is visible from the next cycle. It is stable by the `done` cycle.
- `s_ready` drops in the cycle after the last handshake, so word N+1 is never consumed.
- Throughput in LOAD is one word per cycle. Stalls on `s_valid`=0 hold idx.

## Test plan
- N=4, verify=1, memory models reset to 0. Start, then stream 0x0001..0x0004 back-to-back → `bias_write_en` = 0001,0010,0100,1000 on consecutive cycles; reads in t+2,4,6,8; `done` at t+10; `mismatch`=0.
- Same load with `s_valid` low for 3 cycles between words 1 and 2 → writes follow each handshake by one cycle; no skipped or duplicated index; `done` at last-handshake+10.
- Memory 2 model stuck at 0xFFFF, stream 0x0A00..0x0A03 → `mismatch`=1, `mismatch_idx`=2, verification still reads neuron 3, `done` pulses once.
- `verify`=0, N=4 → no `bias_read_en` activity; `done` two cycles after the last handshake; a fifth `s_valid` word is left unconsumed (`s_ready`=0).
- Assert `reset` after 2 of 4 words → next cycle all outputs 0 and state IDLE; memories 0,1 hold their words. A new `start` reloads from neuron 0 and clears the earlier `mismatch`.
- N=1, verify=1, word 0x1234 → write in t+1, read in t+2, compare in t+3, `done` at t+4, `mismatch`=0. `start` pulsed during busy has no effect.
